// File: rtl/leaf_stream_buffer.sv
// Multi-port stream buffer between leaf_interface and a user operator.
// Every input channel (interface -> user) and every output channel
// (user -> interface) has its own first-word-fall-through FIFO, an
// occupancy output and a saturating count of words popped.

// One first-word-fall-through FIFO channel with occupancy and a
// saturating pop counter. Ready/valid on both sides follow vld && ack.
module leaf_stream_fifo #(
    parameter int W          = 32,
    parameter int DEPTH      = 4,
    parameter int COUNT_BITS = 16,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int OCC_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          in_data,
    input  logic                  in_vld,
    output logic                  in_ack,
    output logic [W-1:0]          out_data,
    output logic                  out_vld,
    input  logic                  out_ack,
    output logic [OCC_W-1:0]      occ,
    output logic [COUNT_BITS-1:0] xfer_cnt
);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [W-1:0]          mem_q [DEPTH];
    logic                  full;
    logic                  push;
    logic                  pop;

    // Handshakes come from registered occupancy only, so ack never depends
    // on vld; both sides are held off while reset is asserted.
    assign full     = (occ_q == OCC_W'(DEPTH));
    assign in_ack   = !full && !reset;
    assign out_vld  = (occ_q != '0) && !reset;
    assign push     = in_vld && in_ack;
    assign pop      = out_vld && out_ack;
    assign out_data = mem_q[rd_ptr_q];
    assign occ      = occ_q;
    assign xfer_cnt = cnt_q;

    // Next-state for pointers, occupancy and the saturating pop counter.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (cnt_q != '1) begin
                cnt_d = cnt_q + COUNT_BITS'(1);
            end
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// Top level: replicates one FIFO per input and per output channel.
module leaf_stream_buffer #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1,
    parameter int DEPTH         = 4,
    parameter int COUNT_BITS    = 16,
    localparam int OCC_W        = $clog2(DEPTH) + 1
) (
    input  logic                                clk_user,
    input  logic                                reset,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_if2buf,
    input  logic [NUM_IN_PORTS-1:0]               vld_if2buf,
    output logic [NUM_IN_PORTS-1:0]               ack_buf2if,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_buf2user,
    output logic [NUM_IN_PORTS-1:0]               vld_buf2user,
    input  logic [NUM_IN_PORTS-1:0]               ack_user2buf,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2buf,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2buf,
    output logic [NUM_OUT_PORTS-1:0]              ack_buf2user,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_buf2if,
    output logic [NUM_OUT_PORTS-1:0]              vld_buf2if,
    input  logic [NUM_OUT_PORTS-1:0]              ack_if2buf,
    output logic [NUM_IN_PORTS*OCC_W-1:0]         occ_in,
    output logic [NUM_OUT_PORTS*OCC_W-1:0]        occ_out,
    output logic [NUM_IN_PORTS*COUNT_BITS-1:0]    xfer_cnt_in,
    output logic [NUM_OUT_PORTS*COUNT_BITS-1:0]   xfer_cnt_out
);

    // Interface -> user channels.
    for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_in
        leaf_stream_fifo #(
            .W          (PAYLOAD_BITS),
            .DEPTH      (DEPTH),
            .COUNT_BITS (COUNT_BITS)
        ) u_fifo (
            .clk      (clk_user),
            .reset    (reset),
            .in_data  (din_if2buf[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .in_vld   (vld_if2buf[p]),
            .in_ack   (ack_buf2if[p]),
            .out_data (dout_buf2user[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .out_vld  (vld_buf2user[p]),
            .out_ack  (ack_user2buf[p]),
            .occ      (occ_in[p*OCC_W +: OCC_W]),
            .xfer_cnt (xfer_cnt_in[p*COUNT_BITS +: COUNT_BITS])
        );
    end

    // User -> interface channels.
    for (genvar p = 0; p < NUM_OUT_PORTS; p++) begin : g_out
        leaf_stream_fifo #(
            .W          (PAYLOAD_BITS),
            .DEPTH      (DEPTH),
            .COUNT_BITS (COUNT_BITS)
        ) u_fifo (
            .clk      (clk_user),
            .reset    (reset),
            .in_data  (din_user2buf[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .in_vld   (vld_user2buf[p]),
            .in_ack   (ack_buf2user[p]),
            .out_data (dout_buf2if[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .out_vld  (vld_buf2if[p]),
            .out_ack  (ack_if2buf[p]),
            .occ      (occ_out[p*OCC_W +: OCC_W]),
            .xfer_cnt (xfer_cnt_out[p*COUNT_BITS +: COUNT_BITS])
        );
    end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed bench for leaf_stream_buffer: three input and three output
// channels, DEPTH 4, 8-bit transfer counters.
module tb_leaf_stream_buffer;

    localparam int PB    = 32;
    localparam int NI    = 3;
    localparam int NO    = 3;
    localparam int DEPTH = 4;
    localparam int CB    = 8;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic              clk_user = 1'b0;
    logic              reset;
    logic [NI*PB-1:0]  din_if2buf;
    logic [NI-1:0]     vld_if2buf;
    logic [NI-1:0]     ack_buf2if;
    logic [NI*PB-1:0]  dout_buf2user;
    logic [NI-1:0]     vld_buf2user;
    logic [NI-1:0]     ack_user2buf;
    logic [NO*PB-1:0]  din_user2buf;
    logic [NO-1:0]     vld_user2buf;
    logic [NO-1:0]     ack_buf2user;
    logic [NO*PB-1:0]  dout_buf2if;
    logic [NO-1:0]     vld_buf2if;
    logic [NO-1:0]     ack_if2buf;
    logic [NI*OW-1:0]  occ_in;
    logic [NO*OW-1:0]  occ_out;
    logic [NI*CB-1:0]  xfer_cnt_in;
    logic [NO*CB-1:0]  xfer_cnt_out;

    int n_assert = 0;
    int n_fail   = 0;

    leaf_stream_buffer #(
        .PAYLOAD_BITS  (PB),
        .NUM_IN_PORTS  (NI),
        .NUM_OUT_PORTS (NO),
        .DEPTH         (DEPTH),
        .COUNT_BITS    (CB)
    ) dut (
        .clk_user      (clk_user),
        .reset         (reset),
        .din_if2buf    (din_if2buf),
        .vld_if2buf    (vld_if2buf),
        .ack_buf2if    (ack_buf2if),
        .dout_buf2user (dout_buf2user),
        .vld_buf2user  (vld_buf2user),
        .ack_user2buf  (ack_user2buf),
        .din_user2buf  (din_user2buf),
        .vld_user2buf  (vld_user2buf),
        .ack_buf2user  (ack_buf2user),
        .dout_buf2if   (dout_buf2if),
        .vld_buf2if    (vld_buf2if),
        .ack_if2buf    (ack_if2buf),
        .occ_in        (occ_in),
        .occ_out       (occ_out),
        .xfer_cnt_in   (xfer_cnt_in),
        .xfer_cnt_out  (xfer_cnt_out)
    );

    always #5 clk_user = ~clk_user;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    function automatic logic [PB-1:0] word_in(input int p);
        return dout_buf2user[p*PB +: PB];
    endfunction

    function automatic logic [PB-1:0] word_out(input int p);
        return dout_buf2if[p*PB +: PB];
    endfunction

    function automatic logic [OW-1:0] oin(input int p);
        return occ_in[p*OW +: OW];
    endfunction

    function automatic logic [OW-1:0] oout(input int p);
        return occ_out[p*OW +: OW];
    endfunction

    function automatic logic [CB-1:0] cin(input int p);
        return xfer_cnt_in[p*CB +: CB];
    endfunction

    function automatic logic [CB-1:0] cout(input int p);
        return xfer_cnt_out[p*CB +: CB];
    endfunction

    function automatic logic [PB-1:0] pat(input int p, input int i);
        return 32'hA000_0000 | (PB'(p) << 16) | PB'(i);
    endfunction

    initial begin
        reset        = 1'b1;
        din_if2buf   = '0;
        vld_if2buf   = '0;
        ack_user2buf = '0;
        din_user2buf = '0;
        vld_user2buf = '0;
        ack_if2buf   = '0;

        // Reset: handshakes held low while asserted, released state after.
        tick();
        tick();
        check("rst_ack_in_low",  64'(ack_buf2if),   64'h0);
        check("rst_ack_out_low", 64'(ack_buf2user), 64'h0);
        check("rst_vld_low",     64'({vld_buf2user, vld_buf2if}), 64'h0);
        reset = 1'b0;
        #1;
        check("post_rst_ack_in",  64'(ack_buf2if),   64'h7);
        check("post_rst_ack_out", 64'(ack_buf2user), 64'h7);
        check("post_rst_vld",     64'({vld_buf2user, vld_buf2if}), 64'h0);
        check("post_rst_occ",     64'({occ_in, occ_out}), 64'h0);
        check("post_rst_cnt",     64'({xfer_cnt_in, xfer_cnt_out}), 64'h0);

        // Single word on input port 0.
        din_if2buf[0 +: PB] = 32'hDEAD_BEEF;
        vld_if2buf = 3'b001;
        tick();
        vld_if2buf = '0;
        check("single_vld",  64'(vld_buf2user), 64'h1);
        check("single_data", 64'(word_in(0)),   64'hDEAD_BEEF);
        check("single_occ",  64'(oin(0)),       64'h1);
        ack_user2buf = 3'b001;
        tick();
        ack_user2buf = '0;
        check("single_vld_after_pop", 64'(vld_buf2user), 64'h0);
        check("single_cnt",           64'(cin(0)),       64'h1);

        // Fill input port 0 with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            din_if2buf[0 +: PB] = PB'(i);
            vld_if2buf = 3'b001;
            tick();
        end
        check("fill_ack_low", 64'(ack_buf2if[0]), 64'h0);
        check("fill_occ",     64'(oin(0)),        64'h4);
        din_if2buf[0 +: PB] = 32'd4;
        tick();
        tick();
        check("full_hold_occ",  64'(oin(0)),      64'h4);
        check("full_hold_head", 64'(word_in(0)),  64'h0);
        // Release the consumer: first pop frees a slot only for the next edge.
        ack_user2buf = 3'b001;
        tick();
        check("drain_head1",   64'(word_in(0)),    64'h1);
        check("drain_ack_up",  64'(ack_buf2if[0]), 64'h1);
        check("drain_occ3",    64'(oin(0)),        64'h3);
        tick();
        vld_if2buf = '0;
        check("drain_head2",   64'(word_in(0)), 64'h2);
        check("drain_occ3b",   64'(oin(0)),     64'h3);
        tick();
        check("drain_head3",   64'(word_in(0)), 64'h3);
        tick();
        check("drain_head4",   64'(word_in(0)), 64'h4);
        check("drain_occ1",    64'(oin(0)),     64'h1);
        tick();
        ack_user2buf = '0;
        check("drain_empty",   64'(vld_buf2user[0]), 64'h0);
        check("drain_cnt",     64'(cin(0)),          64'h6);

        // Streaming 100 words through input port 1 at one word per cycle.
        ack_user2buf = 3'b010;
        for (int i = 0; i <= 100; i++) begin
            din_if2buf[PB +: PB] = pat(1, i);
            vld_if2buf = (i < 100) ? 3'b010 : 3'b000;
            tick();
            if (i < 100) begin
                check("stream_vld",  64'(vld_buf2user[1]), 64'h1);
                check("stream_data", 64'(word_in(1)),      64'(pat(1, i)));
                check("stream_occ",  64'(oin(1)),          64'h1);
            end
        end
        ack_user2buf = '0;
        check("stream_empty", 64'(vld_buf2user[1]), 64'h0);
        check("stream_cnt",   64'(cin(1)),          64'd100);
        check("stream_port0_untouched", 64'(cin(0)), 64'h6);

        // Output side: stall only port 1; ports 0 and 2 keep streaming.
        ack_if2buf = 3'b101;
        for (int i = 0; i <= 10; i++) begin
            for (int p = 0; p < NO; p++) din_user2buf[p*PB +: PB] = pat(p, i);
            vld_user2buf = (i < 10) ? 3'b111 : 3'b000;
            tick();
            if (i < 10) begin
                check("mp_p0_data", 64'(word_out(0)), 64'(pat(0, i)));
                check("mp_p2_data", 64'(word_out(2)), 64'(pat(2, i)));
                check("mp_vld02",   64'({vld_buf2if[2], vld_buf2if[0]}), 64'h3);
            end
        end
        check("mp_p1_occ",  64'(oout(1)),      64'h4);
        check("mp_p1_head", 64'(word_out(1)),  64'(pat(1, 0)));
        check("mp_ack",     64'(ack_buf2user), 64'h5);
        check("mp_cnt0",    64'(cout(0)),      64'd10);
        check("mp_cnt1",    64'(cout(1)),      64'd0);
        check("mp_cnt2",    64'(cout(2)),      64'd10);
        // Pop and offered push on full port 1: only the pop happens.
        din_user2buf[PB +: PB] = 32'h5555_5555;
        vld_user2buf = 3'b010;
        ack_if2buf   = 3'b010;
        tick();
        vld_user2buf = '0;
        ack_if2buf   = '0;
        check("full_pop_occ",  64'(oout(1)),     64'h3);
        check("full_pop_head", 64'(word_out(1)), 64'(pat(1, 1)));
        check("full_pop_cnt",  64'(cout(1)),     64'd1);

        // Saturation: 260 transfers through input port 2.
        ack_user2buf = 3'b100;
        for (int i = 0; i <= 260; i++) begin
            din_if2buf[2*PB +: PB] = PB'(i);
            vld_if2buf = (i < 260) ? 3'b100 : 3'b000;
            tick();
            if (i == 255) check("sat_cnt_255", 64'(cin(2)), 64'd255);
        end
        ack_user2buf = '0;
        check("sat_cnt_end", 64'(cin(2)), 64'd255);

        // Mid-operation reset with three words buffered on input port 0.
        for (int i = 0; i < 3; i++) begin
            din_if2buf[0 +: PB] = 32'h100 + PB'(i);
            vld_if2buf = 3'b001;
            tick();
        end
        vld_if2buf = '0;
        check("pre_rst_occ", 64'(oin(0)), 64'h3);
        reset = 1'b1;
        tick();
        check("mid_rst_ack_in",  64'(ack_buf2if),   64'h0);
        check("mid_rst_ack_out", 64'(ack_buf2user), 64'h0);
        check("mid_rst_vld",     64'({vld_buf2user, vld_buf2if}), 64'h0);
        reset = 1'b0;
        #1;
        check("mid_post_occ", 64'({occ_in, occ_out}), 64'h0);
        check("mid_post_vld", 64'({vld_buf2user, vld_buf2if}), 64'h0);
        check("mid_post_ack", 64'({ack_buf2if, ack_buf2user}), 64'h3F);
        check("mid_post_cnt", 64'({xfer_cnt_in, xfer_cnt_out}), 64'h0);
        din_if2buf[0 +: PB] = 32'h1234_5678;
        vld_if2buf = 3'b001;
        tick();
        vld_if2buf = '0;
        check("after_rst_head", 64'(word_in(0)),      64'h1234_5678);
        check("after_rst_vld",  64'(vld_buf2user[0]), 64'h1);
        check("after_rst_occ",  64'(oin(0)),          64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/leaf_stream_buffer.md
# leaf_stream_buffer

Parametrised multi-port stream buffer between `leaf_interface` and a user operator inside a leaf. It generalises the direct one-port-in, one-port-out vld/ack wiring to NUM_IN_PORTS input channels and NUM_OUT_PORTS output channels. Each channel gets a first-word-fall-through FIFO of configurable depth, so operator stalls and interface backpressure are decoupled. Each channel also has an occupancy output and a saturating transfer counter for debug and throughput measurement.

## Interface
- PAYLOAD_BITS, 32, width of one stream word
- NUM_IN_PORTS, 1, interface→user channels (1..16)
- NUM_OUT_PORTS, 1, user→interface channels (1..16)
- DEPTH, 4, FIFO entries per channel; power of two, ≥2
- COUNT_BITS, 16, width of each transfer counter
- clk_user  in  1  user clock; the only clock
- reset  in  1  synchronous, active-high
- din_if2buf  in  NUM_IN_PORTS*PAYLOAD_BITS  words from interface; port 1 in bits [PAYLOAD_BITS-1:0]
- vld_if2buf  in  NUM_IN_PORTS  per-port valid from interface
- ack_buf2if  out  NUM_IN_PORTS  per-port ack to interface
- dout_buf2user  out  NUM_IN_PORTS*PAYLOAD_BITS  head word of each input FIFO
- vld_buf2user  out  NUM_IN_PORTS  input FIFO non-empty
- ack_user2buf  in  NUM_IN_PORTS  operator consumes head
- din_user2buf  in  NUM_OUT_PORTS*PAYLOAD_BITS  words from operator
- vld_user2buf  in  NUM_OUT_PORTS  per-port valid from operator
- ack_buf2user  out  NUM_OUT_PORTS  ack to operator
- dout_buf2if  out  NUM_OUT_PORTS*PAYLOAD_BITS  head word of each output FIFO
- vld_buf2if  out  NUM_OUT_PORTS  output FIFO non-empty
- ack_if2buf  in  NUM_OUT_PORTS  interface consumes head
- occ_in  out  NUM_IN_PORTS*($clog2(DEPTH)+1)  per-port input FIFO occupancy
- occ_out  out  NUM_OUT_PORTS*($clog2(DEPTH)+1)  per-port output FIFO occupancy
- xfer_cnt_in  out  NUM_IN_PORTS*COUNT_BITS  words popped per input channel
- xfer_cnt_out  out  NUM_OUT_PORTS*COUNT_BITS  words popped per output channel

## Operation
- Every port uses the same vld/ack rule: a word transfers in a cycle iff vld and ack are both high at the rising edge. vld never depends combinationally on ack. Channels are fully independent.
- Per channel there is one FIFO with a write pointer, a read pointer and an occupancy register. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy ranges 0..DEPTH.
- The producer-side ack is !full and is driven only from registered occupancy, with no combinational path from vld.
- Consumer-side vld is occupancy≠0. Data is the entry at the read pointer, always driven and never registered after the read.
- Push and pop in the same cycle: both pointers advance and occupancy is unchanged, including at occupancy 1.
- When full, ack stays low, so no push is possible and no word is lost. A simultaneous pop frees a slot only from the next cycle onward.
- When empty, vld stays low, so no pop is possible. A push becomes visible on the next cycle.
- Transfer counters increment on each consumer-side pop. They saturate at 2^COUNT_BITS−1 and never wrap.
- FIFO storage is distributed/register RAM and is not reset. Only pointers, occupancy and counters reset.

## Timing
- Reset (sampled high at an edge): pointers 0, occupancy 0, counters 0. All vld outputs read 0 and all ack outputs read 1 from the cycle after the reset edge.
- While reset is high, every ack output is forced to 0 and every vld output to 0. A mid-stream reset discards all buffered words and retransmission is not performed.
- Latency from producer transfer to consumer vld is 1 cycle.
- Sustained throughput is 1 word/cycle per channel when the consumer ack is held high.
- Occupancy and counter outputs reflect state after the last edge, with no extra pipeline.

## Test plan
- Single word: DEPTH=4, push 0xDEADBEEF on input port 1 at cycle 0 → vld_buf2user[0]=1 at cycle 1 with data 0xDEADBEEF; ack at cycle 1 → vld=0 at cycle 2, xfer_cnt_in=1.
- Fill/backpressure: hold ack_user2buf=0 and push 0,1,2,3 → ack_buf2if=0 after the 4th push and occ_in=4. A 5th word held valid is not accepted. Release ack → words read 0,1,2,3,4 in order.
- Streaming: vld and ack both held high for 100 cycles with an incrementing pattern → one word per cycle, occupancy constant at 1, counter=100, no gaps.
- Multi-port independence: NUM_IN_PORTS=NUM_OUT_PORTS=3, stall only output port 2 → ports 1 and 3 keep 1 word/cycle and port 2 fills to DEPTH.
- Saturation: COUNT_BITS=4, 20 transfers → xfer_cnt reads 15 and stays 15.
- Reset mid-operation: occupancy 3, assert reset for 1 cycle → acks and vlds low during reset, then occupancy 0, vld 0, ack 1, counters 0. The next pushed word is the first one read.
